// File: rtl/decode_stage_rf.sv
// Decode stage: 16-bit ISA decode, 8-entry register file with writeback bypass,
// RAW scoreboard and a single registered valid/ready output slot.
module decode_stage_rf #(
    parameter int         DATA_W = 16,
    parameter int         PC_W   = 16,
    parameter int         NUM_WB = 2,
    parameter logic [3:0] BR_OP  = 4'hC,
    parameter logic [3:0] ST_OP  = 4'hD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [NUM_WB-1:0]        wb_en,
    input  logic [3*NUM_WB-1:0]      wb_addr,
    input  logic [DATA_W*NUM_WB-1:0] wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_opcode,
    output logic                     out_imm_flag,
    output logic [2:0]               out_rd,
    output logic                     out_rd_we,
    output logic [DATA_W-1:0]        out_op1,
    output logic [DATA_W-1:0]        out_op2,
    output logic                     out_is_branch,
    output logic [PC_W-1:0]          out_branch_target,
    output logic [PC_W-1:0]          out_pc
);

    typedef struct packed {
        logic [3:0]        opcode;
        logic              imm_flag;
        logic [2:0]        rd;
        logic              rd_we;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic              is_branch;
        logic [PC_W-1:0]   branch_target;
        logic [PC_W-1:0]   pc;
    } dec_t;

    logic [DATA_W-1:0] rf [8];
    logic [7:0]        wb_hit;
    logic [DATA_W-1:0] wb_val [8];
    logic [7:0]        pend;
    logic [7:0]        set_mask;
    dec_t              q, d;

    // Collapse the writeback ports into a per-register view; later ports override.
    always_comb begin
        wb_hit = '0;
        for (int r = 0; r < 8; r++) wb_val[r] = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_en[p]) begin
                wb_hit[wb_addr[3*p +: 3]] = 1'b1;
                wb_val[wb_addr[3*p +: 3]] = wb_data[DATA_W*p +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 1; r < 8; r++)
            if (wb_hit[r]) rf[r] <= wb_val[r];
    end

    logic [3:0]        opc;
    logic              imm_f;
    logic [2:0]        rd, rs1, rs2;
    logic [4:0]        imm5;
    logic [DATA_W-1:0] rs1_val, rs2_val, imm_d;
    logic              use1, use2, busy1, busy2, hazard, cap, out_fire;

    always_comb begin
        opc     = in_instr[15:12];
        imm_f   = in_instr[11];
        rd      = in_instr[10:8];
        rs1     = in_instr[7:5];
        rs2     = in_instr[4:2];
        imm5    = in_instr[4:0];
        imm_d   = {{(DATA_W-5){imm5[4]}}, imm5};
        rs1_val = (rs1 == 3'd0) ? '0 : wb_hit[rs1] ? wb_val[rs1] : rf[rs1];
        rs2_val = (rs2 == 3'd0) ? '0 : wb_hit[rs2] ? wb_val[rs2] : rf[rs2];
        use1    = (opc != 4'd0);
        use2    = (opc != 4'd0) && !imm_f;
        // The held instruction's rd counts as in flight even while it is leaving.
        busy1   = (pend[rs1] && !wb_hit[rs1]) || (out_valid && q.rd_we && q.rd == rs1);
        busy2   = (pend[rs2] && !wb_hit[rs2]) || (out_valid && q.rd_we && q.rd == rs2);
        hazard  = (use1 && busy1) || (use2 && busy2);
        in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
        cap      = in_valid && in_ready;
        out_fire = out_valid && out_ready;

        d.opcode        = opc;
        d.imm_flag      = imm_f;
        d.rd            = rd;
        d.rd_we         = (opc != 4'd0) && (opc != BR_OP) && (opc != ST_OP) && (rd != 3'd0);
        d.op1           = rs1_val;
        d.op2           = imm_f ? imm_d : rs2_val;
        d.is_branch     = (opc == BR_OP);
        d.branch_target = in_pc + {{(PC_W-5){imm5[4]}}, imm5};
        d.pc            = in_pc;

        set_mask = '0;
        if (out_fire && q.rd_we) set_mask[q.rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend <= '0;
        else       pend <= ((pend & ~wb_hit) | set_mask) & 8'hFE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (cap) begin
            out_valid <= 1'b1;
            q         <= d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_opcode        = q.opcode;
    assign out_imm_flag      = q.imm_flag;
    assign out_rd            = q.rd;
    assign out_rd_we         = q.rd_we;
    assign out_op1           = q.op1;
    assign out_op2           = q.op2;
    assign out_is_branch     = q.is_branch;
    assign out_branch_target = q.branch_target;
    assign out_pc            = q.pc;

endmodule

// File: tb/tb_decode_stage_rf.sv
// Directed bench for decode_stage_rf: vector table for decode/read paths plus
// hand sequences for RAW stall, output stall, flush and async reset.
module tb_decode_stage_rf;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_instr, in_pc;
    logic [1:0]  wb_en;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  out_opcode;
    logic        out_imm_flag, out_rd_we, out_is_branch;
    logic [2:0]  out_rd;
    logic [15:0] out_op1, out_op2, out_branch_target, out_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage_rf dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_imm_flag(out_imm_flag), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_op1(out_op1), .out_op2(out_op2),
        .out_is_branch(out_is_branch), .out_branch_target(out_branch_target),
        .out_pc(out_pc)
    );

    typedef struct {
        logic [1:0]  wb_en;
        logic [2:0]  a0, a1;
        logic [15:0] d0, d1;
        logic [15:0] instr, pc;
        logic [15:0] op1, op2, tgt;
        logic        rd_we, is_br;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // register state before the table: r2=0202 r3=0012 r4=4444 r5=2222 r7=7070
        vecs[0] = '{2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h2160, 16'h0100, 16'h0012, 16'h0000, 16'h0100, 1'b1, 1'b0};
        vecs[1] = '{2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h36B0, 16'h0020, 16'h2222, 16'h4444, 16'h0010, 1'b1, 1'b0};
        vecs[2] = '{2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h1F8A, 16'h1000, 16'h4444, 16'h000A, 16'h100A, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h4F76, 16'h0005, 16'h0012, 16'hFFF6, 16'hFFFB, 1'b1, 1'b0};
        vecs[4] = '{2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'hC81F, 16'h0004, 16'h0000, 16'hFFFF, 16'h0003, 1'b0, 1'b1};
        vecs[5] = '{2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'hC802, 16'hFFFF, 16'h0000, 16'h0002, 16'h0001, 1'b0, 1'b1};
        vecs[6] = '{2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'hD670, 16'h0040, 16'h0012, 16'h4444, 16'h0030, 1'b0, 1'b0};
        vecs[7] = '{2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0700, 16'h0050, 16'h0000, 16'h0000, 16'h0050, 1'b0, 1'b0};
        vecs[8] = '{2'b11, 3'd2, 3'd2, 16'h5A5A, 16'h0BAD, 16'h5E41, 16'h0010, 16'h0BAD, 16'h0001, 16'h0011, 1'b1, 1'b0};
        vecs[9] = '{2'b01, 3'd3, 3'd0, 16'h7777, 16'h0, 16'h67AC, 16'h0000, 16'h2222, 16'h7777, 16'h000C, 1'b1, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_en = '0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_op1", out_op1, 0);
        chk("rst_out_pc", out_pc, 0);
        reset = 1'b0;

        step();
        wb_en = 2'b11; wb_addr = {3'd4, 3'd3}; wb_data = {16'h4444, 16'h0012}; step();
        wb_addr = {3'd5, 3'd5}; wb_data = {16'h2222, 16'h1111}; step();
        wb_addr = {3'd2, 3'd7}; wb_data = {16'h0202, 16'h7070}; step();
        wb_en = '0;

        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
            wb_en = vecs[i].wb_en; wb_addr = {vecs[i].a1, vecs[i].a0}; wb_data = {vecs[i].d1, vecs[i].d0};
            #1 chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0; wb_en = '0;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_opcode", i), out_opcode, vecs[i].instr[15:12]);
            chk($sformatf("v%0d_rd", i), out_rd, vecs[i].instr[10:8]);
            chk($sformatf("v%0d_op1", i), out_op1, vecs[i].op1);
            chk($sformatf("v%0d_op2", i), out_op2, vecs[i].op2);
            chk($sformatf("v%0d_rd_we", i), out_rd_we, vecs[i].rd_we);
            chk($sformatf("v%0d_is_br", i), out_is_branch, vecs[i].is_br);
            chk($sformatf("v%0d_target", i), out_branch_target, vecs[i].tgt);
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
        end
        step();
        chk("drain_valid", out_valid, 0);

        // RAW: second instruction waits on r2 until a writeback bypasses it in
        reset = 1'b1; #2 chk("rawrst_valid", out_valid, 0); reset = 1'b0;
        step();
        in_valid = 1'b1; in_instr = 16'h2A60; in_pc = 16'h0200; out_ready = 1'b0;
        #1 chk("raw_first_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("raw_first_valid", out_valid, 1);
        in_instr = 16'h3C40; in_pc = 16'h0202;
        #1 chk("raw_held_ready", in_ready, 0);
        out_ready = 1'b1;
        #1 chk("raw_leaving_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("raw_gone_valid", out_valid, 0);
        chk("raw_pending_ready", in_ready, 0);
        step();
        chk("raw_pending2_ready", in_ready, 0);
        wb_en = 2'b10; wb_addr = {3'd2, 3'd0}; wb_data = {16'h00AB, 16'h0000};
        #1 chk("raw_bypass_ready", in_ready, 1);
        @(posedge clk); #1;
        wb_en = '0; in_valid = 1'b0;
        chk("raw_bypass_valid", out_valid, 1);
        chk("raw_bypass_op1", out_op1, 16'h00AB);
        chk("raw_bypass_pc", out_pc, 16'h0202);
        step();

        // output stall, then flush coinciding with the handshake
        reset = 1'b1; #2 reset = 1'b0;
        step();
        in_valid = 1'b1; in_instr = 16'h1F8A; in_pc = 16'h1000; out_ready = 1'b0;
        @(posedge clk); #1;
        in_instr = 16'h36B0; in_pc = 16'h0020;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
            chk($sformatf("stall%0d_valid", c), out_valid, 1);
            chk($sformatf("stall%0d_op1", c), out_op1, 16'h4444);
            chk($sformatf("stall%0d_op2", c), out_op2, 16'h000A);
            chk($sformatf("stall%0d_target", c), out_branch_target, 16'h100A);
            chk($sformatf("stall%0d_pc", c), out_pc, 16'h1000);
            @(posedge clk); #1;
        end
        flush = 1'b1; out_ready = 1'b1;
        #1 chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_valid", out_valid, 0);
        in_instr = 16'h1EE0; in_pc = 16'h0400;
        #1 chk("flush_sb_kept", in_ready, 0);
        step();

        // hold an instruction, stall a pending-source one, then reset mid-stall
        in_instr = 16'h2A60; in_pc = 16'h0300;
        #1 chk("hold_ready", in_ready, 1);
        @(posedge clk); #1;
        in_instr = 16'h1EE0; in_pc = 16'h0400;
        #1 chk("stall_pending_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_op1", out_op1, 0);
        chk("arst_rd", out_rd, 0);
        chk("arst_in_ready", in_ready, 0);
        #1 reset = 1'b0;
        #1 chk("post_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_op1", out_op1, 16'h7070);
        chk("post_rst_pc", out_pc, 16'h0400);
        step();
        chk("post_rst_drain", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_rf.md
Name: decode_stage_rf

Overview:
- Parametrised decode stage for the superscalar core. Sits between fetch and issue.
- Decodes the 16-bit ISA and holds an architectural register file with NUM_WB writeback ports. Reads operands with same-cycle writeback bypass.
- Tracks in-flight destinations in a scoreboard to stall RAW hazards.
- Presents one decoded instruction per cycle behind a valid/ready handshake. Supports flush on taken branch.

Parameters:
- DATA_W, 16, register/operand width.
- PC_W, 16, program counter width.
- NUM_WB, 2, number of writeback ports.
- BR_OP, 4'hC, branch opcode.
- ST_OP, 4'hD, store opcode (no rd write).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  taken-branch kill of decode contents.
- in_valid  in  1  fetch has instruction.
- in_ready  out  1  decode accepts this cycle.
- in_instr  in  16  instruction.
- in_pc  in  PC_W  instruction address.
- wb_en  in  NUM_WB  per-port write enable.
- wb_addr  in  3*NUM_WB  per-port destination register.
- wb_data  in  DATA_W*NUM_WB  per-port data.
- out_valid  out  1  decoded instruction valid.
- out_ready  in  1  issue accepts.
- out_opcode  out  4  instr[15:12].
- out_imm_flag  out  1  instr[11].
- out_rd  out  3  instr[10:8].
- out_rd_we  out  1  instruction writes rd.
- out_op1  out  DATA_W  value of rs1.
- out_op2  out  DATA_W  rs2 value, or sign-extended imm.
- out_is_branch  out  1  opcode==BR_OP.
- out_branch_target  out  PC_W  in_pc + sext(imm5).
- out_pc  out  PC_W  pc of decoded instruction.

Behaviour:
- Clock is clk. Reset is reset: asynchronous, active-high.
- Instruction format: opcode [15:12], imm_flag [11], rd [10:8], rs1 [7:5], rs2 [4:2], imm5 [4:0].
- Register file: 8 x DATA_W. r0 reads 0 always; writes to r0 are ignored. Contents are not cleared by reset.
- Writes happen on the clk edge for each port with wb_en set. If several ports hit the same register, the highest port index wins.
- Operand read is combinational at capture:
  - If any wb port writes that register in the same cycle, bypass wb_data (highest index wins).
  - Otherwise return the file contents.
- rd_we = (opcode != 0) && (opcode != BR_OP) && (opcode != ST_OP) && (rd != 0).
- Sources used:
  - rs1 always, except opcode 0 (NOP).
  - rs2 only when imm_flag = 0 and opcode != 0.
- Scoreboard: 8 pending bits.
  - Set bit[out_rd] on the out handshake (out_valid && out_ready && out_rd_we).
  - Clear bit[a] when any wb port writes a.
  - Same cycle set and clear on one register: set wins.
  - r0 is never pending.
- hazard = a used source s is pending and not written by a wb port this cycle, OR out_valid && out_rd_we && out_rd == s (including when that instruction is leaving this cycle).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Capture on in_valid && in_ready: register all out_* fields next edge and set out_valid. Latency is 1 cycle.
- Register contents:
  - op2 = imm_flag ? sext(imm5) to DATA_W : rs2 value.
  - branch_target = in_pc + sext(imm5), modulo 2^PC_W (wrap-around).
- Handshake:
  - Output holds stable while out_valid && !out_ready.
  - out_valid clears when issue takes the instruction and there is no new capture.
- flush: out_valid <= 0 next edge and in_ready = 0 that cycle. An out handshake in the same cycle as flush still counts for the scoreboard. Scoreboard and register file are otherwise untouched, because older in-flight instructions still write back.
- Reset:
  - out_valid = 0, scoreboard = 0.
  - All out_* data outputs = 0.
  - in_ready = 0 during reset.
  - Reset mid-stall drops the held instruction.

Test Plan:
- Reset, then wb port0 writes r3 = 16'h0012. Instruction 16'h2_0_1_60 is op 2, imm_flag 0, rd 1, rs1 3, rs2 0. Result: out_op1 = 0x0012, out_op2 = 0, out_rd_we = 1, out_valid 1 cycle after capture.
- Back-to-back RAW: op 2 rd 2, then op 3 rs1 2.
  - in_ready stays low while the first instruction is held and pending.
  - wb port1 writes r2 = 0x00AB: the second instruction captures that same cycle with out_op1 = 0x00AB via bypass.
- Both wb ports write r5 in one cycle (0x1111 on port0, 0x2222 on port1) -> later read of r5 = 0x2222.
- Branch 16'hC81F at in_pc = 0x0004 (imm5 = -1) -> out_is_branch = 1, out_branch_target = 0x0003, out_rd_we = 0. Wrap case: in_pc = 0xFFFF with imm5 = 2 -> target 0x0001.
- out_ready low for 3 cycles -> all outputs stable and in_ready = 0. Assert flush -> out_valid = 0 next cycle, scoreboard unchanged.
- Reset asserted asynchronously mid-stall -> out_valid drops immediately and the scoreboard clears. A pending-source instruction is accepted on the first cycle after reset release.
